// File: rtl/thing_sched_pkg.sv
// Shared constants and state encoding for the two-requester session scheduler.
package thing_sched_pkg;

  localparam logic [7:0] CH_SEMI   = 8'd59;
  localparam logic [7:0] CH_DOLLAR = 8'd36;

  typedef enum logic [2:0] {
    StArb,
    StCapture,
    StStart,
    StFeed,
    StPopWait,
    StDrain
  } state_e;

endpackage

// File: rtl/thing_sched_sess_buf.sv
// Session byte buffer plus per-segment pop-count table; write pointers live here,
// reads are asynchronous by the replay pointers supplied from outside.
module thing_sched_sess_buf
  import thing_sched_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned MAX_SEG = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_we,
  input  logic [7:0]                   i_data,
  input  logic                         i_num_we,
  input  logic [3:0]                   i_num,
  input  logic [$clog2(DEPTH)-1:0]     i_rd_ptr,
  input  logic [$clog2(MAX_SEG+1)-1:0] i_seg_rd,
  output logic [$clog2(DEPTH)-1:0]     o_wr_ptr,
  output logic [$clog2(MAX_SEG+1)-1:0] o_seg_cnt,
  output logic [7:0]                   o_rd_data,
  output logic [3:0]                   o_rd_num
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(MAX_SEG + 1);
  localparam int unsigned IW = $clog2(MAX_SEG);
  localparam logic [SW-1:0] SegLimit = SW'(MAX_SEG);

  logic [7:0]    r_mem [DEPTH];
  logic [3:0]    r_num [MAX_SEG];
  logic [AW-1:0] r_wr_ptr;
  logic [SW-1:0] r_seg_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr  <= '0;
      r_seg_cnt <= '0;
    end else begin
      if (i_we)     r_wr_ptr  <= r_wr_ptr + 1'b1;
      if (i_num_we) r_seg_cnt <= r_seg_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) r_mem[r_wr_ptr] <= i_data;
    if (i_num_we && (r_seg_cnt < SegLimit)) r_num[r_seg_cnt[IW-1:0]] <= i_num;
  end

  assign o_wr_ptr  = r_wr_ptr;
  assign o_seg_cnt = r_seg_cnt;
  assign o_rd_data = r_mem[i_rd_ptr];
  // Past the last segment (the '$' byte) there is no table entry to show.
  assign o_rd_num  = (i_seg_rd < SegLimit) ? r_num[i_seg_rd[IW-1:0]] : 4'd0;

endmodule

// File: rtl/thing_sched.sv
// Round-robin session scheduler: captures a whole session from the granted
// requester, then replays it into the shared stack engine with exact timing.
module thing_sched
  import thing_sched_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned MAX_SEG = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [3:0] req_num0,
  input  logic [3:0] req_num1,
  output logic [1:0] req_ready,
  output logic       eng_ready,
  output logic [7:0] eng_thing_in,
  output logic [3:0] eng_thing_num,
  input  logic       eng_done_thing,
  input  logic       eng_valid_lifo,
  input  logic       eng_valid_fifo2,
  input  logic       eng_done_fifo2,
  input  logic [7:0] eng_thing_out,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_owner,
  output logic       out_kind,
  output logic       busy,
  output logic       err_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(MAX_SEG + 1);
  localparam logic [AW-1:0] PtrLast  = AW'(DEPTH - 1);
  localparam logic [SW-1:0] SegLimit = SW'(MAX_SEG);

  state_e        r_state, w_state_d;
  logic          r_grant, w_grant_d;
  logic          r_last_grant, w_last_grant_d;
  logic [AW-1:0] r_rd_ptr, w_rd_ptr_d;
  logic [SW-1:0] r_seg_rd, w_seg_rd_d;
  logic [3:0]    r_item_cnt, w_item_cnt_d;
  logic          r_err_ovf, w_err_ovf_d;

  logic          w_we, w_num_we, w_clr;
  logic [AW-1:0] w_wr_ptr;
  logic [SW-1:0] w_seg_cnt;
  logic [7:0]    w_rd_data;
  logic [3:0]    w_rd_num;
  logic [7:0]    w_byte;
  logic [3:0]    w_num;
  logic          w_acc, w_ovf, w_is_semi, w_is_dollar, w_is_item;

  thing_sched_sess_buf #(
    .DEPTH  (DEPTH),
    .MAX_SEG(MAX_SEG)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_we     (w_we),
    .i_data   (w_byte),
    .i_num_we (w_num_we),
    .i_num    (w_num),
    .i_rd_ptr (r_rd_ptr),
    .i_seg_rd (r_seg_rd),
    .o_wr_ptr (w_wr_ptr),
    .o_seg_cnt(w_seg_cnt),
    .o_rd_data(w_rd_data),
    .o_rd_num (w_rd_num)
  );

  assign w_byte      = r_grant ? req_data1 : req_data0;
  assign w_num       = r_grant ? req_num1 : req_num0;
  assign w_is_semi   = (w_byte == CH_SEMI);
  assign w_is_dollar = (w_byte == CH_DOLLAR);
  assign w_is_item   = !w_is_semi && !w_is_dollar;
  assign w_acc       = (r_state == StCapture) && req_valid[r_grant];
  // The 16th item would not fit the 4-bit pop count, so it ends the session.
  assign w_ovf       = w_acc && ((!w_is_dollar && (w_wr_ptr == PtrLast)) ||
                                 (w_is_semi && (w_seg_cnt == SegLimit)) ||
                                 (w_is_item && (r_item_cnt == 4'd15)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StArb;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rd_ptr     <= '0;
      r_seg_rd     <= '0;
      r_item_cnt   <= '0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_grant      <= w_grant_d;
      r_last_grant <= w_last_grant_d;
      r_rd_ptr     <= w_rd_ptr_d;
      r_seg_rd     <= w_seg_rd_d;
      r_item_cnt   <= w_item_cnt_d;
      r_err_ovf    <= w_err_ovf_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_grant_d      = r_grant;
    w_last_grant_d = r_last_grant;
    w_rd_ptr_d     = r_rd_ptr;
    w_seg_rd_d     = r_seg_rd;
    w_item_cnt_d   = r_item_cnt;
    w_err_ovf_d    = 1'b0;
    w_we           = 1'b0;
    w_num_we       = 1'b0;
    w_clr          = 1'b0;
    req_ready      = 2'b00;
    eng_ready      = 1'b0;
    eng_thing_in   = 8'd0;
    eng_thing_num  = 4'd0;
    out_kind       = 1'b0;
    unique case (r_state)
      StArb: begin
        if (|req_valid) begin
          w_grant_d      = (&req_valid) ? ~r_last_grant : req_valid[1];
          w_last_grant_d = w_grant_d;
          w_state_d      = StCapture;
        end
      end
      StCapture: begin
        req_ready[r_grant] = 1'b1;
        if (w_ovf) begin
          w_err_ovf_d  = 1'b1;
          w_clr        = 1'b1;
          w_item_cnt_d = '0;
          w_state_d    = StArb;
        end else if (w_acc) begin
          w_we     = 1'b1;
          w_num_we = w_is_semi;
          if (w_is_item)   w_item_cnt_d = r_item_cnt + 4'd1;
          if (w_is_dollar) w_state_d    = StStart;
        end
      end
      StStart: begin
        eng_ready  = 1'b1;
        w_rd_ptr_d = '0;
        w_seg_rd_d = '0;
        w_state_d  = StFeed;
      end
      StFeed: begin
        eng_thing_in  = w_rd_data;
        eng_thing_num = w_rd_num;
        w_rd_ptr_d    = r_rd_ptr + 1'b1;
        if (w_rd_data == CH_SEMI)        w_state_d = StPopWait;
        else if (w_rd_data == CH_DOLLAR) w_state_d = StDrain;
      end
      StPopWait: begin
        eng_thing_num = w_rd_num;
        if (eng_done_thing) begin
          w_seg_rd_d = r_seg_rd + 1'b1;
          w_state_d  = StFeed;
        end
      end
      StDrain: begin
        out_kind = 1'b1;
        if (eng_done_fifo2) begin
          w_clr        = 1'b1;
          w_rd_ptr_d   = '0;
          w_seg_rd_d   = '0;
          w_item_cnt_d = '0;
          w_state_d    = StArb;
        end
      end
      default: w_state_d = StArb;
    endcase
  end

  assign out_valid = eng_valid_lifo | eng_valid_fifo2;
  assign out_data  = eng_thing_out;
  assign out_owner = r_grant;
  assign busy      = (r_state != StArb);
  assign err_ovf   = r_err_ovf;

endmodule

// File: doc/thing_sched.md
Name: thing_sched

Overview:
- Session-level scheduler that shares one LIFO/FIFO stack engine between two byte-stream requesters.
- Grants one requester at a time, round-robin per session. A session is a byte stream of items, ';' (8'd59) segment terminators and a final '$' (8'd36).
- Buffers the whole granted session, then replays it into the engine with exact engine timing. The engine has no backpressure on its write side.
- Tags engine output with the owning requester.

Parameters:
- DEPTH, 32, session buffer entries (bytes incl. terminators); power of two
- MAX_SEG, 8, max ';' segments per session (thing_num table size)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  2  per-requester byte valid
- req_data0  in  8  requester 0 byte
- req_data1  in  8  requester 1 byte
- req_num0  in  4  requester 0 pop count, sampled with ';'
- req_num1  in  4  requester 1 pop count, sampled with ';'
- req_ready  out  2  per-requester accept; byte transfers when valid&ready
- eng_ready  out  1  engine start pulse
- eng_thing_in  out  8  byte to engine
- eng_thing_num  out  4  pop count to engine
- eng_done_thing  in  1  engine LIFO pop complete
- eng_valid_lifo  in  1  engine LIFO output valid
- eng_valid_fifo2  in  1  engine FIFO output valid
- eng_done_fifo2  in  1  engine FIFO drain complete
- eng_thing_out  in  8  engine output byte
- out_valid  out  1  eng_valid_lifo | eng_valid_fifo2
- out_data  out  8  eng_thing_out passthrough
- out_owner  out  1  current grant index
- out_kind  out  1  0 = LIFO pop, 1 = FIFO drain
- busy  out  1  state != ARB
- err_ovf  out  1  one-cycle pulse, session discarded

Behaviour:
- Reset values: state ARB, wr/rd/seg pointers 0, last_grant 1 (so requester 0 wins first), req_ready 0, eng_ready 0, eng_thing_in 0, eng_thing_num 0, err_ovf 0, out_owner 0.
- ARB:
  - If any req_valid is set, grant round-robin: prefer !last_grant when both are valid.
  - Register grant and last_grant, then go to CAPTURE next cycle.
  - No byte is accepted in ARB.
- CAPTURE:
  - req_ready[grant] = 1; the other requester's ready = 0.
  - Each accepted byte is written to buf[wr_ptr] and wr_ptr increments.
  - On ';': store req_num[grant] in num_tab[seg_cnt] and increment seg_cnt.
  - On '$': go to START.
  - Overflow: a non-'$' byte accepted with wr_ptr == DEPTH-1, a ';' with seg_cnt == MAX_SEG, or item count (non-terminator bytes) reaching 16. Then pulse err_ovf, clear the pointers and return to ARB. The offending byte is consumed.
- START: eng_ready = 1 for exactly one cycle; rd_ptr = 0, seg_rd = 0; next state FEED.
- FEED:
  - eng_thing_in = buf[rd_ptr] and rd_ptr increments every cycle, with no gaps (the engine samples every W_DATA cycle).
  - eng_thing_num = num_tab[seg_rd], valid from the first byte of the segment.
  - Byte ';' → POP_WAIT next cycle. Byte '$' → DRAIN next cycle.
- POP_WAIT:
  - eng_thing_in = 0.
  - eng_thing_num holds num_tab[seg_rd] stable until eng_done_thing.
  - On eng_done_thing: increment seg_rd and return to FEED next cycle. The first byte of the next segment is driven in the cycle after done.
  - A thing_num of 0 needs no special case; the engine emits one '0' and asserts done.
- DRAIN: eng_thing_in = 0; wait for eng_done_fifo2, then clear the pointers and go to ARB next cycle.
- out_kind is 1 in DRAIN, else 0. out_owner = grant.
- Empty session ('$' as first byte) is forwarded normally; the engine asserts done_fifo2 immediately.
- The other requester is never granted mid-session. Its bytes stall via ready = 0.
- Reset mid-session aborts to ARB with no err_ovf. The engine shares rst, so both restart together.
- Latency: first engine byte appears 2 cycles after the '$' handshake (START + FEED).

Decomposition:
- Shared package: CH_SEMI = 8'd59, CH_DOLLAR = 8'd36; state encoding ARB, CAPTURE, START, FEED, POP_WAIT, DRAIN.
- One sub-module, sess_buf: DEPTH x 8 byte RAM plus MAX_SEG x 4 num table.
  - Write port: data, we, num_we.
  - Async read by rd_ptr and seg_rd.
  - Pointer clear input.

Test Plan:
- Req0 sends "1","2","3",";"(num=2),"$" → engine fed 1,2,3,;,$ on consecutive cycles except a POP_WAIT gap. out_data 3,2 (kind 0, owner 0), then 1 (kind 1). Returns to ARB.
- Both requesters valid at reset release → req0 granted first, req1 granted after req0's done_fifo2. Req1 ready stays 0 throughout req0's session.
- Segment with num=0 → engine emits '0' (8'd48) once with owner tag. The next segment's first byte is driven in the cycle after eng_done_thing.
- Session of 16 items without '$' → err_ovf one-cycle pulse, no eng_ready pulse, grant passes to the other requester.
- Empty session "$" → eng_ready pulse, then '$' driven; done_fifo2 arrives with no out_valid; back to ARB.
- rst asserted during POP_WAIT → next cycle: busy 0, req_ready 0, eng_thing_num 0; a fresh session then runs correctly.
